// File: rtl/stage_result_fifo.sv
// stage_result_fifo: fall-through result FIFO with level, sticky overflow, pop counter and optional checksum
// Ports: clk, rst (async active-high); in_valid/in_data/in_ready upstream handshake;
//   out_valid/out_data/out_ready downstream handshake; level = occupancy 0..DEPTH;
//   overflow = sticky "offered while full"; checksum = running sum of accepted words
//   (only when STAGE_RESULT_FIFO_CHECKSUM_EN is defined, else 0); pop_count = words delivered.
module stage_result_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  input  logic        out_ready,
  output logic [4:0]  level,
  output logic        overflow,
  output logic [31:0] checksum,
  output logic [31:0] pop_count
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} state_t;
  state_t state, state_nx;
  logic [31:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic push, pop;
  assign in_ready  = level != 5'(DEPTH);
  assign out_valid = level != 5'd0;
  assign out_data  = out_valid ? mem[rd_ptr] : 32'd0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  always_comb begin
    state_nx = EMPTY;
    case (state)
      EMPTY:   state_nx = push ? PARTIAL : EMPTY;
      PARTIAL: state_nx = (push && !pop && level == 5'(DEPTH - 1)) ? FULL :
                          (pop && !push && level == 5'd1) ? EMPTY : PARTIAL;
      FULL:    state_nx = pop ? PARTIAL : FULL;
      default: state_nx = EMPTY;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      pop_count <= '0;
    end else begin
      state     <= state_nx;
      wr_ptr    <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr    <= pop ? rd_ptr + 1'b1 : rd_ptr;
      level     <= level + 5'(push) - 5'(pop);
      overflow  <= overflow | (in_valid & ~in_ready);
      pop_count <= pop_count + 32'(pop);
    end
  end
  // Storage is deliberately left out of reset; pointers and level alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end
`ifdef STAGE_RESULT_FIFO_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) checksum <= '0;
    else     checksum <= push ? checksum + in_data : checksum;
  end
`else
  assign checksum = 32'd0;
`endif
endmodule

// File: tb/tb_stage_result_fifo.sv
// tb_stage_result_fifo: table-driven plus scoreboard bench for stage_result_fifo (DEPTH=4)
module tb_stage_result_fifo;
  localparam int DEPTH = 4;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready = 1'b0;
  logic [4:0]  level;
  logic        overflow;
  logic [31:0] checksum;
  logic [31:0] pop_count;
  stage_result_fifo #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .level(level),
    .overflow(overflow), .checksum(checksum), .pop_count(pop_count)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic [4:0]  lvl;
    logic        ov;
  } vec_t;
  vec_t tbl[$];
  logic [31:0] q[$];
  logic        ov_m = 1'b0;
  logic [31:0] pc_m = '0;
  logic [31:0] cs_m = '0;
  int checks = 0;
  int errors = 0;
  function automatic vec_t mk(logic v, logic [31:0] d, logic r, logic [4:0] lvl, logic ov);
    vec_t t;
    t.v = v; t.d = d; t.r = r; t.lvl = lvl; t.ov = ov;
    return t;
  endfunction
  task automatic check(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endtask
  task automatic do_cycle(input logic v, input logic [31:0] d, input logic r);
    logic pu, po;
    in_valid = v; in_data = d; out_ready = r;
    #1;
    check("out_valid", 32'(out_valid), 32'(q.size() != 0));
    check("out_data", out_data, q.size() != 0 ? q[0] : 32'd0);
    check("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    pu = v && q.size() != DEPTH;
    po = r && q.size() != 0;
    if (v && !pu) ov_m = 1'b1;
    @(posedge clk);
    #1;
    if (po) begin
      void'(q.pop_front());
      pc_m++;
    end
    if (pu) begin
      q.push_back(d);
`ifdef STAGE_RESULT_FIFO_CHECKSUM_EN
      cs_m += d;
`endif
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("level", 32'(level), 32'(q.size()));
    check("overflow", 32'(overflow), 32'(ov_m));
    check("pop_count", pop_count, pc_m);
    check("checksum", checksum, cs_m);
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    #1;
    check("rst_level", 32'(level), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_pop_count", pop_count, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    q.delete(); ov_m = 1'b0; pc_m = '0; cs_m = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    logic [31:0] exp_cs;
    tbl.push_back(mk(1, 32'h2, 0, 1, 0));
    tbl.push_back(mk(1, 32'h5, 0, 2, 0));
    tbl.push_back(mk(1, 32'h3, 0, 3, 0));
    tbl.push_back(mk(0, 0, 1, 2, 0));
    tbl.push_back(mk(0, 0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 1, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 32'h100 + 32'(i), 0, 5'(i < 4 ? i + 1 : 4), i == 4));
    for (int i = 0; i < 4; i++) tbl.push_back(mk(0, 0, 1, 5'(3 - i), 1));
    tbl.push_back(mk(1, 32'h10, 0, 1, 1));
    tbl.push_back(mk(1, 32'h11, 0, 2, 1));
    tbl.push_back(mk(1, 32'h7, 1, 2, 1));
    tbl.push_back(mk(0, 0, 1, 1, 1));
    tbl.push_back(mk(0, 0, 1, 0, 1));
    @(posedge clk);
    #1;
    rst_pulse();
    foreach (tbl[i]) begin
      do_cycle(tbl[i].v, tbl[i].d, tbl[i].r);
      check($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      check($sformatf("tbl%0d_overflow", i), 32'(overflow), 32'(tbl[i].ov));
      if (i == 5) check("pop_count_three", pop_count, 32'd3);
    end
    rst_pulse();
    do_cycle(1, 32'hFFFF_FFFF, 0);
    do_cycle(1, 32'h2, 0);
`ifdef STAGE_RESULT_FIFO_CHECKSUM_EN
    exp_cs = 32'h1;
`else
    exp_cs = 32'h0;
`endif
    check("checksum_wrap", checksum, exp_cs);
    rst_pulse();
    for (int i = 0; i < 3; i++) do_cycle(1, 32'h50 + 32'(i), 0);
    rst_pulse();
    do_cycle(1, 32'hA, 0);
    check("post_rst_data", out_data, 32'hA);
    do_cycle(0, 0, 1);
    rst_pulse();
    for (int i = 0; i < 20; i++) begin
      do_cycle(1, $urandom, 0);
      do_cycle(0, 0, 1);
    end
    check("wrap_pop_count", pop_count, 32'd20);
    check("wrap_level", 32'(level), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/stage_result_fifo.md
STAGE_RESULT_FIFO -- requirements
Module: stage_result_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning the number of 32-bit entries; legal values are 2, 4, 8 and 16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream stage presents a word.
REQ-005 The block SHALL have port in_data, input, 32 bits: the word from the upstream arithmetic stage.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the FIFO can accept a word.
REQ-007 The block SHALL have port out_valid, output, 1 bit: the head entry is valid.
REQ-008 The block SHALL have port out_data, output, 32 bits: the head entry.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes the head.
REQ-010 The block SHALL have port level, output, 5 bits: the current occupancy, 0..DEPTH.
REQ-011 The block SHALL have port overflow, output, 1 bit: sticky flag for a word offered while full.
REQ-012 The block SHALL have port checksum, output, 32 bits: the running sum of accepted words (see Configuration).
REQ-013 The block SHALL have port pop_count, output, 32 bits: the number of words delivered downstream.

Function
REQ-014 The FIFO SHALL push when in_valid && in_ready, and pop when out_valid && out_ready, both on the rising edge of clk.
REQ-015 in_ready SHALL equal (level != DEPTH), combinationally; when full, no push occurs even if a pop happens in the same cycle.
REQ-016 out_valid SHALL equal (level != 0); out_data SHALL be the head entry read combinationally, with zero-cycle fall-through from the storage array.
REQ-017 Latency SHALL be one cycle: a word pushed at edge N is visible on out_data/out_valid after edge N.
REQ-018 A simultaneous push and pop with 0 < level < DEPTH SHALL leave level unchanged and keep FIFO order.
REQ-019 Read and write pointers SHALL each be log2(DEPTH) bits and wrap from DEPTH-1 to 0; level is tracked by a separate counter.
REQ-020 The control FSM SHALL have states EMPTY, PARTIAL and FULL:
- EMPTY->PARTIAL on a push.
- PARTIAL->FULL when a push without a pop brings level to DEPTH.
- PARTIAL->EMPTY when a pop without a push brings level to 0.
- FULL->PARTIAL on a pop.
- Any other state encoding SHALL go to EMPTY.
REQ-021 overflow SHALL set on any edge where in_valid=1 and in_ready=0, and SHALL stay set until reset.
REQ-022 pop_count SHALL increment by 1 per pop, wrapping from 0xFFFFFFFF to 0.
REQ-023 When out_valid=0, out_data SHALL be 0; it SHALL not show stale storage.

Reset
REQ-024 On rst=1, the block SHALL asynchronously clear the pointers, set level=0, FSM=EMPTY, overflow=0, checksum=0 and pop_count=0.
REQ-025 During reset, in_ready SHALL be 1, out_valid 0 and out_data 0.
REQ-026 Reset mid-operation SHALL discard all stored entries; the storage array itself is not cleared.
REQ-027 The first push SHALL be accepted on the first rising edge after rst deasserts.

Configuration
REQ-028 Macro STAGE_RESULT_FIFO_CHECKSUM_EN SHALL control the checksum logic.
REQ-029 With the macro defined, checksum SHALL add in_data (mod 2^32) on every push.
REQ-030 Without the macro, checksum SHALL be tied to 0 and no adder SHALL be synthesized.

Verification
REQ-031 The bench SHALL cover these scenarios:
- Reset, then push 0x2, 0x5, 0x3 with out_ready=0 -> level=3; then out_ready=1 -> out_data 0x2, 0x5, 0x3 in order; pop_count=3.
- DEPTH=4: push 5 words with out_ready=0 -> 5th refused, in_ready=0, level=4, overflow=1 and still 1 after draining.
- level=2, push 0x7 and pop the same cycle -> level stays 2; 0x7 exits after the two older words.
- CHECKSUM_EN defined: push 0xFFFFFFFF then 0x2 -> checksum=0x1. Undefined: checksum=0.
- Push 3 words, assert rst mid-cycle -> out_valid=0 and level=0 immediately; a following push of 0xA appears as out_data=0xA.
- 20 push/pop pairs at DEPTH=4 -> pointers wrap, data order preserved, pop_count=20.
